// File: rtl/pacman_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : pacman_pkg                                         |
// | Description : Shared types for the Pacman movement controller:   |
// |               heading encoding, controller states, reset heading |
// |               and the button priority encoder.                   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    DECIDE = 2'd1,
    REQ    = 2'd2
  } state_t;

  localparam dir_t DIR_RESET = LEFT;

  // Simultaneous presses resolve UP > RIGHT > DOWN > LEFT.
  function automatic dir_t btn_priority(input logic up, input logic right,
                                        input logic down);
    if (up)
      return UP;
    else if (right)
      return RIGHT;
    else if (down)
      return DOWN;
    else
      return LEFT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : move_tick_gen                                      |
// | Description : Movement pacing counter. Counts 0..TICK_CYCLES-1   |
// |               while en is high and pulses tick on the last count.|
// |               Held at zero while en is low.                      |
// | Ports       : CLOCK_50 clock, reset sync active-high,            |
// |               en count enable, tick one-cycle pacing pulse       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module move_tick_gen #(
  parameter int TICK_CYCLES = 2_500_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W  = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == C_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset || !en)
      r_cnt <= '0;
    else if (w_last)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign tick = en && w_last;

endmodule
`default_nettype wire

// File: rtl/pacman_move_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : pacman_move_ctrl                                   |
// | Description : Buffers the latest requested turn, paces movement  |
// |               with a tick, decides each tick between turning,    |
// |               going straight or stopping, and issues the step as |
// |               a req/ack handshake to the position register.      |
// | Ports       : CLOCK_50, reset (sync, active-high)                |
// |               btn_up/right/down/left  one-cycle button pulses    |
// |               game_en   game running                             |
// |               dir_open  passable directions, indexed by dir_t    |
// |               move_ack  position logic accepted the step         |
// |               move_req/move_dir  step request and its direction  |
// |               cur_dir, moving, pend_valid  status                |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module pacman_move_ctrl
  import pacman_pkg::*;
#(
  parameter int TICK_CYCLES = 2_500_000,
  parameter int PEND_HOLD   = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       game_en,
  input  logic [3:0] dir_open,
  input  logic       move_ack,
  output logic       move_req,
  output logic [1:0] move_dir,
  output logic [1:0] cur_dir,
  output logic       moving,
  output logic       pend_valid
);

  localparam int               AGE_W       = $clog2(PEND_HOLD + 1);
  localparam logic [AGE_W-1:0] C_AGE_LIMIT = AGE_W'(PEND_HOLD);

  logic             w_tick;
  state_t           r_state;
  state_t           w_state_next;
  dir_t             r_cur_dir;
  dir_t             r_move_dir;
  dir_t             r_pend_dir;
  logic             r_moving;
  logic             r_pend_valid;
  logic [AGE_W-1:0] r_pend_age;
  logic [AGE_W-1:0] w_age_inc;
  logic             w_btn_any;
  dir_t             w_btn_dir;
  logic             w_take_turn;
  logic             w_go_straight;
  logic             w_move_req;

  move_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .en      (game_en),
    .tick    (w_tick)
  );

  assign w_btn_any     = btn_up | btn_right | btn_down | btn_left;
  assign w_btn_dir     = btn_priority(btn_up, btn_right, btn_down);
  // Decision inputs use the pending buffer as it stood before this edge,
  // so a press landing on the DECIDE cycle only affects the next decision.
  assign w_take_turn   = r_pend_valid && dir_open[r_pend_dir];
  assign w_go_straight = !w_take_turn && dir_open[r_cur_dir];
  assign w_age_inc     = r_pend_age + AGE_W'(1);

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset)
      r_state <= WAIT;
    else
      r_state <= w_state_next;
  end

  // Next-state logic; ticks outside WAIT are simply not looked at.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT:    if (w_tick && game_en) w_state_next = DECIDE;
      DECIDE:  w_state_next = (game_en && (w_take_turn || w_go_straight)) ? REQ : WAIT;
      REQ:     if (move_ack) w_state_next = WAIT;
      default: w_state_next = WAIT;
    endcase
  end

  // Output decode
  always_comb begin
    w_move_req = 1'b0;
    if (r_state == REQ) w_move_req = 1'b1;
  end

  // Heading, step direction and pending-turn buffer
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_cur_dir    <= DIR_RESET;
      r_move_dir   <= DIR_RESET;
      r_pend_dir   <= DIR_RESET;
      r_moving     <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_age   <= '0;
    end else begin
      if (r_state == DECIDE && game_en) begin
        if (w_take_turn) begin
          r_cur_dir    <= r_pend_dir;
          r_move_dir   <= r_pend_dir;
          r_moving     <= 1'b1;
          r_pend_valid <= 1'b0;
          r_pend_age   <= '0;
        end else begin
          r_moving <= w_go_straight;
          if (w_go_straight) r_move_dir <= r_cur_dir;
          // An unusable pending turn ages out after PEND_HOLD decisions.
          if (r_pend_valid) begin
            if (w_age_inc == C_AGE_LIMIT) begin
              r_pend_valid <= 1'b0;
              r_pend_age   <= '0;
            end else begin
              r_pend_age <= w_age_inc;
            end
          end
        end
      end
      // A fresh press always wins over the decision's buffer update.
      if (w_btn_any) begin
        r_pend_dir   <= w_btn_dir;
        r_pend_valid <= 1'b1;
        r_pend_age   <= '0;
      end
      // Leaving the game clears status; an open handshake still completes.
      if (!game_en) begin
        r_pend_valid <= 1'b0;
        r_moving     <= 1'b0;
      end
    end
  end

  assign move_req   = w_move_req;
  assign move_dir   = r_move_dir;
  assign cur_dir    = r_cur_dir;
  assign moving     = r_moving;
  assign pend_valid = r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_pacman_move_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_pacman_move_ctrl                                |
// | Description : Self-checking bench for pacman_move_ctrl with a    |
// |               cycle-level behavioural model, directed scenarios  |
// |               and a randomized soak.                             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_pacman_move_ctrl;

  localparam int TICK_CYCLES = 4;
  localparam int PEND_HOLD   = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       game_en  = 1'b0;
  logic [3:0] dir_open = 4'b0000;
  logic       move_ack = 1'b0;
  logic       move_req;
  logic [1:0] move_dir;
  logic [1:0] cur_dir;
  logic       moving;
  logic       pend_valid;

  int n_assert = 0;
  int n_fail   = 0;

  pacman_move_ctrl #(
    .TICK_CYCLES(TICK_CYCLES),
    .PEND_HOLD  (PEND_HOLD)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .game_en   (game_en),
    .dir_open  (dir_open),
    .move_ack  (move_ack),
    .move_req  (move_req),
    .move_dir  (move_dir),
    .cur_dir   (cur_dir),
    .moving    (moving),
    .pend_valid(pend_valid)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Plain integers: cycle position in the tick period, whether a decision
  // is due on the next edge, whether a step is being offered, and the
  // pending-turn record (direction, validity, decisions survived).
  int m_cnt, m_mdir, m_cur, m_pd, m_age;
  bit m_live = 0, m_decide_due, m_offer, m_moving, m_pv;

  always @(posedge CLOCK_50) begin
    bit tick_now;
    if (reset) begin
      m_live = 1; m_cnt = 0; m_decide_due = 0; m_offer = 0;
      m_mdir = 3; m_cur = 3; m_pd = 3; m_moving = 0; m_pv = 0; m_age = 0;
    end else if (m_live) begin
      tick_now = game_en && (m_cnt == TICK_CYCLES - 1);
      m_cnt    = game_en ? ((m_cnt + 1) % TICK_CYCLES) : 0;
      if (m_decide_due) begin
        m_decide_due = 0;
        if (!game_en) begin
          m_moving = 0;
        end else if (m_pv && dir_open[m_pd]) begin
          m_cur = m_pd; m_mdir = m_pd; m_pv = 0; m_age = 0; m_moving = 1; m_offer = 1;
        end else begin
          if (dir_open[m_cur]) begin m_moving = 1; m_mdir = m_cur; m_offer = 1; end
          else m_moving = 0;
          if (m_pv) begin
            m_age = m_age + 1;
            if (m_age == PEND_HOLD) begin m_pv = 0; m_age = 0; end
          end
        end
      end else if (m_offer) begin
        if (move_ack) m_offer = 0;
      end else if (tick_now) begin
        m_decide_due = 1;
      end
      if (btn_up | btn_right | btn_down | btn_left) begin
        m_pd  = btn_up ? 0 : btn_right ? 1 : btn_down ? 2 : 3;
        m_pv  = 1;
        m_age = 0;
      end
      if (!game_en) begin m_pv = 0; m_moving = 0; end
    end
  end

  // One compare process: every cycle after the first reset.
  always @(negedge CLOCK_50) begin
    if (m_live) begin
      chk("model move_req",   {31'd0, move_req},   {31'd0, m_offer});
      chk("model move_dir",   {30'd0, move_dir},   m_mdir);
      chk("model cur_dir",    {30'd0, cur_dir},    m_cur);
      chk("model moving",     {31'd0, moving},     {31'd0, m_moving});
      chk("model pend_valid", {31'd0, pend_valid}, {31'd0, m_pv});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_req(input string name);
    int n = 0;
    while (move_req !== 1'b1 && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (move_req !== 1'b1) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: actual=no move_req required=move_req within 40 cycles", name);
    end
  endtask

  task automatic ack_once();
    move_ack = 1'b1;
    @(negedge CLOCK_50);
    move_ack = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] b);
    {btn_up, btn_right, btn_down, btn_left} = b;
    @(negedge CLOCK_50);
    {btn_up, btn_right, btn_down, btn_left} = 4'b0000;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("reset move_req",   {31'd0, move_req},   0);
    chk("reset move_dir",   {30'd0, move_dir},   3);
    chk("reset cur_dir",    {30'd0, cur_dir},    3);
    chk("reset moving",     {31'd0, moving},     0);
    chk("reset pend_valid", {31'd0, pend_valid}, 0);

    // Straight on from rest in the reset heading.
    game_en = 1'b1; dir_open = 4'b1000;
    wait_req("first req");
    chk("first move_dir", {30'd0, move_dir}, 3);
    ack_once();
    chk("first req drop", {31'd0, move_req}, 0);
    chk("first moving",   {31'd0, moving},   1);

    // Buffered turn taken into an open direction.
    dir_open = 4'b0001;
    pulse(4'b1000);
    chk("up pend_valid", {31'd0, pend_valid}, 1);
    wait_req("up req");
    chk("up move_dir",   {30'd0, move_dir},   0);
    chk("up cur_dir",    {30'd0, cur_dir},    0);
    chk("up pend clear", {31'd0, pend_valid}, 0);
    ack_once();

    // Blocked turn ages out after PEND_HOLD decisions.
    pulse(4'b0010);
    wait_req("down req1");
    chk("down pend after 1", {31'd0, pend_valid}, 1);
    ack_once();
    wait_req("down req2");
    chk("down pend after 2", {31'd0, pend_valid}, 0);
    chk("down heading kept", {30'd0, cur_dir},    0);
    ack_once();

    // Simultaneous UP+LEFT: UP wins (LEFT would give move_dir 3).
    dir_open = 4'b1001;
    pulse(4'b1001);
    wait_req("prio req");
    chk("prio move_dir", {30'd0, move_dir}, 0);
    ack_once();

    // Held request stays stable; intervening ticks are dropped.
    wait_req("hold req");
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      chk("hold move_req", {31'd0, move_req}, 1);
      chk("hold move_dir", {30'd0, move_dir}, 0);
    end
    ack_once();
    chk("hold drop", {31'd0, move_req}, 0);

    // Walls all round: Pacman stops.
    dir_open = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLOCK_50);
      chk("wall no req", {31'd0, move_req}, 0);
    end
    chk("wall moving", {31'd0, moving}, 0);

    // Turn from rest, then leave the game mid-handshake.
    dir_open = 4'b1000;
    pulse(4'b0001);
    wait_req("left req");
    chk("left move_dir", {30'd0, move_dir}, 3);
    pulse(4'b1000);
    chk("mid pend", {31'd0, pend_valid}, 1);
    game_en = 1'b0;
    @(negedge CLOCK_50);
    chk("off pend",    {31'd0, pend_valid}, 0);
    chk("off req held",{31'd0, move_req},   1);
    ack_once();
    chk("off req drop", {31'd0, move_req}, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLOCK_50);
      chk("off no req", {31'd0, move_req}, 0);
    end

    // Reset in the middle of a request.
    game_en = 1'b1; dir_open = 4'b0100;
    pulse(4'b0010);
    wait_req("rst req");
    chk("rst pre cur_dir", {30'd0, cur_dir}, 2);
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("rst move_req", {31'd0, move_req}, 0);
    chk("rst cur_dir",  {30'd0, cur_dir},  3);
    chk("rst moving",   {31'd0, moving},   0);
    reset = 1'b0;

    // Randomized soak against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) game_en = ~game_en;
      if (game_en && $urandom_range(0, 5) == 0)
        {btn_up, btn_right, btn_down, btn_left} = 4'($urandom);
      else
        {btn_up, btn_right, btn_down, btn_left} = 4'b0000;
      dir_open = 4'($urandom);
      move_ack = ($urandom_range(0, 2) == 0);
      @(negedge CLOCK_50);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
